// File: rtl/spi_pkg.sv
// Shared definitions for the spi_master slice: FSM encoding, command bit values, frame length.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  localparam logic CMD_READ  = 1'b1;
  localparam logic CMD_WRITE = 1'b0;
  localparam int   NBITS     = 16;

endpackage

// File: rtl/spi_clkgen.sv
// Half-period timer: tick marks the last clk of each CLKDIV-long phase; clear restarts it on state entry.
module spi_clkgen #(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CNTW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(CLKDIV - 1);

  logic [CNTW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNTW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one 16-bit frame {addr, rw, data} per accepted start, MSB first.
import spi_pkg::*;

module spi_master #(
  parameter int CLKDIV = 4,
  parameter int ADDRW  = 7,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             rw,
  input  logic [ADDRW-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             sclk_pin,
  output logic             cs_pin,
  output logic             mosi_pin,
  input  logic             miso_pin,
  output spi_state_e       dbg_state
);

  // Request/response: start is taken only while busy=0 (IDLE) and is never queued;
  // busy stays high until done pulses for one cycle, and rdata is valid from that pulse.

  localparam int SW = ADDRW + 1 + WIDTH;

  spi_state_e     state, state_nx;
  logic           tick;
  logic [SW-1:0]  shift;
  logic [WIDTH-1:0] rx;
  logic [4:0]     bit_cnt;
  logic           rw_q;
  logic           miso_s1, miso_s2;
  logic           done_r;

  spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_nx != state),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_SETUP;
      ST_SETUP: if (tick)  state_nx = ST_HIGH;
      ST_HIGH:  if (tick)  state_nx = ST_LOW;
      ST_LOW:   if (tick)  state_nx = (bit_cnt == 5'(NBITS)) ? ST_GAP : ST_HIGH;
      ST_GAP:   if (tick)  state_nx = ST_IDLE;
      default:             state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    cs_pin    = 1'b1;
    sclk_pin  = 1'b0;
    mosi_pin  = 1'b0;
    done      = done_r;
    dbg_state = state;
    if (state == ST_SETUP || state == ST_HIGH || state == ST_LOW) begin
      cs_pin   = 1'b0;
      mosi_pin = shift[SW-1];
    end
    if (state == ST_HIGH) sclk_pin = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
    end else begin
      miso_s1 <= miso_pin;
      miso_s2 <= miso_s1;
    end
  end

  // rx is only WIDTH wide, so the command-phase miso bits fall off the top by the end of the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift   <= '0;
      rx      <= '0;
      bit_cnt <= '0;
      rw_q    <= CMD_WRITE;
      rdata   <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            shift   <= {addr, rw, (rw == CMD_READ) ? {WIDTH{1'b0}} : wdata};
            rw_q    <= rw;
            bit_cnt <= '0;
          end
        end
        ST_HIGH: begin
          if (tick) begin
            shift   <= {shift[SW-2:0], 1'b0};
            rx      <= {rx[WIDTH-2:0], miso_s2};
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        ST_GAP: begin
          if (tick) begin
            done_r <= 1'b1;
            if (rw_q == CMD_READ) rdata <= rx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLKDIV 4 and 3) each talking to a behavioural SPI memory slave.
module tb_spi_master;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] start, rw, busy, done, sclk, cs, mosi;
  logic [6:0] addr  [2];
  logic [7:0] wdata [2];
  logic [7:0] rdata [2];
  spi_state_e dbg_state [2];

  logic [15:0] mon_word  [2];
  logic [4:0]  mon_rises [2];
  int          mon_cs    [2];
  int          mon_dones [2];

  int checks   = 0;
  int failures = 0;

  logic [7:0] ref_mem   [2][128];
  logic [7:0] exp_rdata [2];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int H = (g == 0) ? 4 : 3;
    logic        miso_r;
    logic        prev_cs;
    logic        prev_sclk;
    logic [15:0] word;
    logic [4:0]  rises;
    int          cs_cyc;
    int          dones;
    logic [7:0]  mem [128];
    logic [7:0]  cmd_now;
    logic [7:0]  rd_byte;

    spi_master #(.CLKDIV(H), .ADDRW(7), .WIDTH(8)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start[g]),
      .rw        (rw[g]),
      .addr      (addr[g]),
      .wdata     (wdata[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .rdata     (rdata[g]),
      .sclk_pin  (sclk[g]),
      .cs_pin    (cs[g]),
      .mosi_pin  (mosi[g]),
      .miso_pin  (miso_r),
      .dbg_state (dbg_state[g])
    );

    // Slave view: command byte is the 8 bits most recently shifted in before the data phase.
    assign cmd_now = 8'(word >> (rises - 5'd8));
    assign rd_byte = mem[cmd_now[7:1]];

    initial begin
      for (int a = 0; a < 128; a++) mem[a] = 8'(a) ^ 8'h39;
      miso_r    = 1'b0;
      prev_cs   = 1'b1;
      prev_sclk = 1'b0;
      word      = '0;
      rises     = '0;
      cs_cyc    = 0;
      dones     = 0;
    end

    always @(negedge clk) begin
      prev_cs   <= cs[g];
      prev_sclk <= sclk[g];
      if (prev_cs && !cs[g]) begin
        word   <= '0;
        rises  <= '0;
        cs_cyc <= 1;
        dones  <= 0;
        miso_r <= 1'($urandom_range(0, 1));
      end else begin
        if (!cs[g]) cs_cyc <= cs_cyc + 1;
        if (done[g]) dones <= dones + 1;
        if (!cs[g] && !prev_sclk && sclk[g]) begin
          word  <= {word[14:0], mosi[g]};
          rises <= rises + 5'd1;
          if (rises == 5'd15 && !word[7]) mem[word[14:8]] <= {word[6:0], mosi[g]};
        end
        if (!cs[g] && prev_sclk && !sclk[g]) begin
          if (rises >= 5'd8 && rises < 5'd16 && cmd_now[0])
            miso_r <= rd_byte[3'(5'd15 - rises)];
          else
            miso_r <= 1'($urandom_range(0, 1));
        end
      end
    end

    assign mon_word[g]  = word;
    assign mon_rises[g] = rises;
    assign mon_cs[g]    = cs_cyc;
    assign mon_dones[g] = dones;
  end

  function automatic int hdiv(input int idx);
    return (idx == 0) ? 4 : 3;
  endfunction

  function automatic logic [15:0] frame(input logic [6:0] a, input logic r, input logic [7:0] wd);
    return 16'(a) * 16'd512 + 16'(r) * 16'd256 + (r ? 16'd0 : 16'(wd));
  endfunction

  // Launch one transaction; inputs are scrambled after acceptance, optional extra start at cycle poke_at.
  task automatic do_txn(input int idx, input logic [6:0] a, input logic r, input logic [7:0] wd,
                        input int poke_at, output int lat, output logic busy_first, output logic busy_done);
    lat = -1;
    busy_first = 1'b0;
    busy_done = 1'b1;
    @(negedge clk);
    addr[idx] = a; rw[idx] = r; wdata[idx] = wd; start[idx] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      start[idx] = (n == poke_at);
      addr[idx]  = 7'($urandom);
      rw[idx]    = 1'($urandom);
      wdata[idx] = 8'($urandom);
      if (n == 1) busy_first = busy[idx];
      if (done[idx]) begin
        lat = n;
        busy_done = busy[idx];
        break;
      end
    end
    start[idx] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = '0; rw = '0;
    for (int i = 0; i < 2; i++) begin addr[i] = '0; wdata[i] = '0; end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({cs[i], sclk[i], mosi[i], busy[i], done[i]} !== 5'b10000) begin
        failures++;
        $display("FAIL reset_pins[%0d] got cs,sclk,mosi,busy,done=%b exp=10000", i,
                 {cs[i], sclk[i], mosi[i], busy[i], done[i]});
      end
      checks++;
      if (rdata[i] !== 8'h00) begin
        failures++;
        $display("FAIL reset_rdata[%0d] got=%h exp=00", i, rdata[i]);
      end
      checks++;
      if (dbg_state[i] !== ST_IDLE) begin
        failures++;
        $display("FAIL reset_state[%0d] got=%0d exp=%0d", i, dbg_state[i], ST_IDLE);
      end
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int lat; logic bf, bd;
    do_txn(0, 7'h2A, CMD_WRITE, 8'hA5, 0, lat, bf, bd);
    ref_mem[0][7'h2A] = 8'hA5;
    checks++;
    if (mon_word[0] !== 16'h54A5) begin
      failures++; $display("FAIL write_mosi got=%h exp=54a5", mon_word[0]);
    end
    checks++;
    if (mon_rises[0] !== 5'd16) begin
      failures++; $display("FAIL write_rises got=%0d exp=16", mon_rises[0]);
    end
    checks++;
    if (mon_cs[0] != 33 * 4) begin
      failures++; $display("FAIL write_cs_low got=%0d exp=%0d", mon_cs[0], 33 * 4);
    end
    checks++;
    if (mon_dones[0] != 1) begin
      failures++; $display("FAIL write_done_count got=%0d exp=1", mon_dones[0]);
    end
    checks++;
    if (lat != 137) begin
      failures++; $display("FAIL write_latency got=%0d exp=137", lat);
    end
    checks++;
    if (bf !== 1'b1 || bd !== 1'b0) begin
      failures++; $display("FAIL write_busy got first=%b at_done=%b exp first=1 at_done=0", bf, bd);
    end
    checks++;
    if (rdata[0] !== exp_rdata[0]) begin
      failures++; $display("FAIL write_rdata_held got=%h exp=%h", rdata[0], exp_rdata[0]);
    end
  endtask

  task automatic test_read();
    int lat; logic bf, bd;
    do_txn(0, 7'h05, CMD_READ, 8'hFF, 0, lat, bf, bd);
    exp_rdata[0] = ref_mem[0][7'h05];
    checks++;
    if (mon_word[0] !== 16'h0B00) begin
      failures++; $display("FAIL read_mosi got=%h exp=0b00", mon_word[0]);
    end
    checks++;
    if (rdata[0] !== 8'h3C) begin
      failures++; $display("FAIL read_rdata got=%h exp=3c", rdata[0]);
    end
    checks++;
    if (lat != 137) begin
      failures++; $display("FAIL read_latency got=%0d exp=137", lat);
    end
  endtask

  task automatic test_write_read();
    int lat; logic bf, bd;
    do_txn(0, 7'h11, CMD_WRITE, 8'hC3, 0, lat, bf, bd);
    ref_mem[0][7'h11] = 8'hC3;
    checks++;
    if (rdata[0] !== exp_rdata[0]) begin
      failures++; $display("FAIL wr_rd_after_write got=%h exp=%h", rdata[0], exp_rdata[0]);
    end
    do_txn(0, 7'h11, CMD_READ, 8'h00, 0, lat, bf, bd);
    exp_rdata[0] = ref_mem[0][7'h11];
    checks++;
    if (rdata[0] !== 8'hC3) begin
      failures++; $display("FAIL wr_rd_readback got=%h exp=c3", rdata[0]);
    end
  endtask

  task automatic test_start_mid();
    int lat; logic bf, bd;
    do_txn(0, 7'h2A, CMD_WRITE, 8'hA5, 50, lat, bf, bd);
    repeat (200) @(negedge clk);
    checks++;
    if (mon_word[0] !== 16'h54A5 || mon_cs[0] != 132 || mon_rises[0] !== 5'd16) begin
      failures++;
      $display("FAIL start_mid_wave got word=%h cs=%0d rises=%0d exp word=54a5 cs=132 rises=16",
               mon_word[0], mon_cs[0], mon_rises[0]);
    end
    checks++;
    if (mon_dones[0] != 1 || lat != 137) begin
      failures++; $display("FAIL start_mid_done got dones=%0d lat=%0d exp dones=1 lat=137", mon_dones[0], lat);
    end
    checks++;
    if (busy[0] !== 1'b0) begin
      failures++; $display("FAIL start_mid_not_queued got busy=%b exp=0", busy[0]);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic bf, bd;
    @(negedge clk);
    addr[0] = 7'h2A; rw[0] = CMD_WRITE; wdata[0] = 8'hA5; start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (69) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({cs[0], sclk[0], mosi[0], busy[0]} !== 4'b1000) begin
      failures++; $display("FAIL abort_pins got cs,sclk,mosi,busy=%b exp=1000", {cs[0], sclk[0], mosi[0], busy[0]});
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    repeat (200) @(negedge clk);
    checks++;
    if (mon_dones[0] != 0 || busy[0] !== 1'b0) begin
      failures++; $display("FAIL abort_no_done got dones=%0d busy=%b exp dones=0 busy=0", mon_dones[0], busy[0]);
    end
    checks++;
    if (rdata[0] !== 8'h00) begin
      failures++; $display("FAIL abort_rdata got=%h exp=00", rdata[0]);
    end
    do_txn(0, 7'h33, CMD_WRITE, 8'h5A, 0, lat, bf, bd);
    ref_mem[0][7'h33] = 8'h5A;
    checks++;
    if (mon_word[0] !== frame(7'h33, CMD_WRITE, 8'h5A) || lat != 137 || mon_dones[0] != 1) begin
      failures++; $display("FAIL abort_recover got word=%h lat=%0d dones=%0d exp word=%h lat=137 dones=1",
                           mon_word[0], lat, mon_dones[0], frame(7'h33, CMD_WRITE, 8'h5A));
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] a1, a2;
    int gap, n;
    logic seen_done;
    a1 = 7'($urandom);
    a2 = a1 + 7'd9;
    gap = 0;
    seen_done = 1'b0;
    @(negedge clk);
    addr[1] = a1; rw[1] = CMD_READ; wdata[1] = 8'($urandom); start[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    addr[1] = a2;
    n = 0;
    while (cs[1] !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    while (cs[1] === 1'b1 && n < 1000) begin
      gap++;
      if (done[1]) begin
        seen_done = 1'b1;
        checks++;
        if (rdata[1] !== ref_mem[1][a1]) begin
          failures++; $display("FAIL b2b_rdata_first got=%h exp=%h", rdata[1], ref_mem[1][a1]);
        end
      end
      @(negedge clk); n++;
    end
    start[1] = 1'b0;
    checks++;
    if (!seen_done || gap < 3) begin
      failures++; $display("FAIL b2b_gap got gap=%0d done_seen=%b exp gap>=3 done_seen=1", gap, seen_done);
    end
    n = 0;
    while (!done[1] && n < 1000) begin @(negedge clk); n++; end
    exp_rdata[1] = ref_mem[1][a2];
    checks++;
    if (!done[1] || rdata[1] !== ref_mem[1][a2]) begin
      failures++; $display("FAIL b2b_rdata_second got=%h done=%b exp=%h done=1", rdata[1], done[1], ref_mem[1][a2]);
    end
    checks++;
    if (mon_word[1] !== frame(a2, CMD_READ, 8'h00)) begin
      failures++; $display("FAIL b2b_mosi_second got=%h exp=%h", mon_word[1], frame(a2, CMD_READ, 8'h00));
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    int lat, idx; logic bf, bd;
    logic [6:0] a; logic r; logic [7:0] wd, exp_v;
    for (int i = 0; i < 12; i++) begin
      idx = $urandom_range(0, 1);
      a   = 7'($urandom_range(0, 127));
      r   = 1'($urandom_range(0, 1));
      wd  = 8'($urandom_range(0, 255));
      do_txn(idx, a, r, wd, 0, lat, bf, bd);
      if (r == CMD_READ) begin
        exp_q.push_back(ref_mem[idx][a]);
        exp_v = exp_q.pop_front();
        exp_rdata[idx] = exp_v;
      end else begin
        ref_mem[idx][a] = wd;
        exp_v = exp_rdata[idx];
      end
      checks++;
      if (mon_word[idx] !== frame(a, r, wd)) begin
        failures++; $display("FAIL rand_mosi[%0d] got=%h exp=%h", i, mon_word[idx], frame(a, r, wd));
      end
      checks++;
      if (rdata[idx] !== exp_v) begin
        failures++; $display("FAIL rand_rdata[%0d] got=%h exp=%h", i, rdata[idx], exp_v);
      end
      checks++;
      if (lat != 34 * hdiv(idx) + 1 || mon_cs[idx] != 33 * hdiv(idx)) begin
        failures++; $display("FAIL rand_timing[%0d] got lat=%0d cs=%0d exp lat=%0d cs=%0d", i, lat, mon_cs[idx],
                             34 * hdiv(idx) + 1, 33 * hdiv(idx));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      exp_rdata[i] = 8'h00;
      for (int a = 0; a < 128; a++) ref_mem[i][a] = 8'(a) ^ 8'h39;
    end
    test_reset();
    test_write();
    test_read();
    test_write_read();
    test_start_mid();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
